wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: integer results write directly, FPU results
// queue in a small FIFO and drain on cycles the integer pipe leaves idle.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_valid,
  input  logic [4:0]  int_rd,
  input  logic [31:0] int_data,
  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic [4:0]  fpu_rd,
  input  logic [31:0] fpu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;
  logic             r_we;
  logic [4:0]       r_a3;
  logic [31:0]      r_wd3;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_int_take;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic [31:0] w_busy_next;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign fpu_ready   = !w_full && !rst;
  assign w_push      = fpu_valid && fpu_ready;
  assign w_int_take  = int_valid && (int_rd != 5'd0);
  // The pop decision uses the pre-edge count, so an entry is never popped at its push edge.
  assign w_pop       = (r_count != '0) && !w_int_take;
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // NOTE: every variable assigned in always_comb gets a default first; otherwise a latch is inferred.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) w_busy_next[w_head_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  assign hazard = r_busy[q_rs1] | r_busy[q_rs2];
  assign rf_we  = r_we;
  assign rf_a3  = r_a3;
  assign rf_wd3 = r_wd3;

  // NOTE: FIFO storage has no reset; validity is tracked by r_count, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= fpu_rd;
      r_fifo_data[r_wptr] <= fpu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_we    <= 1'b0;
      r_a3    <= 5'd0;
      r_wd3   <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_int_take) begin
        r_we  <= 1'b1;
        r_a3  <= int_rd;
        r_wd3 <= int_data;
      end else if (w_pop) begin
        r_we  <= (w_head_rd != 5'd0);
        r_a3  <= w_head_rd;
        r_wd3 <= w_head_data;
      end else begin
        r_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: each task drives one scenario and checks
// hand-computed writeback, fpu_ready and hazard values inline.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid;
  logic [4:0]  int_rd;
  logic [31:0] int_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_rd(int_rd), .int_data(int_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard(hazard),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] wr(input logic we, input logic [4:0] a3, input logic [31:0] wd3);
    return {we, a3, wd3};
  endfunction

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_valid = 1'b0; int_rd = 5'd0; int_data = 32'd0;
    fpu_valid = 1'b0; fpu_rd = 5'd0; fpu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    fpu_valid = 1'b1;
    #1;
    n_checks++;
    if (fpu_ready !== 1'b0) begin
      $display("FAIL reset_ready_low: got %b want 0", fpu_ready); n_fail++;
    end
    tick();
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b0, 5'd0, 32'd0)) begin
      $display("FAIL reset_outputs: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b0, 5'd0, 32'd0)); n_fail++;
    end
    n_checks++;
    if (hazard !== 1'b0) begin
      $display("FAIL reset_hazard: got %b want 0", hazard); n_fail++;
    end
    rst = 1'b0;
    fpu_valid = 1'b0;
    #1;
    n_checks++;
    if (fpu_ready !== 1'b1) begin
      $display("FAIL reset_ready_after: got %b want 1", fpu_ready); n_fail++;
    end
  endtask

  task automatic test_int_write();
    apply_reset();
    int_valid = 1'b1; int_rd = 5'd5; int_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b1, 5'd5, 32'hDEADBEEF)) begin
      $display("FAIL int_write: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b1, 5'd5, 32'hDEADBEEF)); n_fail++;
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL int_write_one_cycle: got we=%b want 0", rf_we); n_fail++;
    end
  endtask

  task automatic test_int_rd0();
    apply_reset();
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h0000_0011;
    int_valid = 1'b1; int_rd = 5'd0; int_data = 32'h1234_5678;
    tick();
    fpu_valid = 1'b0;
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL int_rd0_no_write: got we=%b want 0", rf_we); n_fail++;
    end
    tick();
    idle_inputs();
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b1, 5'd9, 32'h0000_0011)) begin
      $display("FAIL int_rd0_no_block: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b1, 5'd9, 32'h0000_0011)); n_fail++;
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL int_rd0_drain: got we=%b want 0", rf_we); n_fail++;
    end
  endtask

  task automatic test_fpu_hazard();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    q_rs1 = 5'd3;
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F80_0000;
    #1;
    n_checks++;
    if (hazard !== 1'b1) begin
      $display("FAIL hazard_after_issue: got %b want 1", hazard); n_fail++;
    end
    n_checks++;
    if (fpu_ready !== 1'b1) begin
      $display("FAIL fpu_ready_empty: got %b want 1", fpu_ready); n_fail++;
    end
    tick();
    fpu_valid = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || hazard !== 1'b1) begin
      $display("FAIL fpu_min_latency: got we=%b hazard=%b want we=0 hazard=1", rf_we, hazard); n_fail++;
    end
    tick();
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b1, 5'd3, 32'h3F80_0000)) begin
      $display("FAIL fpu_write: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b1, 5'd3, 32'h3F80_0000)); n_fail++;
    end
    n_checks++;
    if (hazard !== 1'b0) begin
      $display("FAIL busy_cleared_on_pop: got %b want 0", hazard); n_fail++;
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL fpu_write_one_cycle: got we=%b want 0", rf_we); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_wr [6];
    logic        exp_rdy [6];
    exp_wr[0] = wr(1'b1, 5'd10, 32'h0000_00A0); exp_rdy[0] = 1'b1;
    exp_wr[1] = wr(1'b1, 5'd11, 32'h0000_00A1); exp_rdy[1] = 1'b0;
    exp_wr[2] = wr(1'b1, 5'd12, 32'h0000_00A2); exp_rdy[2] = 1'b0;
    exp_wr[3] = wr(1'b1, 5'd13, 32'h0000_00A3); exp_rdy[3] = 1'b0;
    exp_wr[4] = wr(1'b1, 5'd20, 32'h0000_00F0); exp_rdy[4] = 1'b1;
    exp_wr[5] = wr(1'b1, 5'd21, 32'h0000_00F1); exp_rdy[5] = 1'b1;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      int_valid = (i < 4);
      int_rd    = 5'(10 + i);
      int_data  = 32'h0000_00A0 + 32'(i);
      // Two results taken on the first two edges; a third is offered while full and must be refused.
      fpu_valid = (i < 4);
      fpu_rd    = (i < 2) ? 5'(20 + i) : 5'd22;
      fpu_data  = (i < 2) ? 32'h0000_00F0 + 32'(i) : 32'h0000_00FF;
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if ({rf_we, rf_a3, rf_wd3} !== exp_wr[i]) begin
        $display("FAIL b2b_write[%0d]: got %h want %h", i, {rf_we, rf_a3, rf_wd3}, exp_wr[i]); n_fail++;
      end
      n_checks++;
      if (fpu_ready !== exp_rdy[i]) begin
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, fpu_ready, exp_rdy[i]); n_fail++;
      end
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL b2b_no_extra: got we=%b want 0", rf_we); n_fail++;
    end
  endtask

  task automatic test_fpu_rd0();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd0;
    fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'h0000_0055;
    tick();
    idle_inputs();
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    #1;
    n_checks++;
    if (hazard !== 1'b0) begin
      $display("FAIL hazard_reg0: got %b want 0", hazard); n_fail++;
    end
    tick();
    n_checks++;
    if ({rf_we, rf_a3} !== 6'd0) begin
      $display("FAIL fpu_rd0_discard: got we=%b a3=%0d want we=0 a3=0", rf_we, rf_a3); n_fail++;
    end
    q_rs1 = 5'd4;
    #1;
    n_checks++;
    if (hazard !== 1'b1) begin
      $display("FAIL fpu_rd0_busy_kept: got %b want 1", hazard); n_fail++;
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin
      $display("FAIL fpu_rd0_empty: got we=%b want 0", rf_we); n_fail++;
    end
  endtask

  task automatic test_set_clear_same();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h0000_0077;
    tick();
    fpu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    q_rs2 = 5'd7;
    #1;
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b1, 5'd7, 32'h0000_0077)) begin
      $display("FAIL setclr_write: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b1, 5'd7, 32'h0000_0077)); n_fail++;
    end
    n_checks++;
    if (hazard !== 1'b1) begin
      $display("FAIL setclr_busy_kept: got %b want 1", hazard); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd12;
    fpu_valid = 1'b1; fpu_rd = 5'd12; fpu_data = 32'h0000_0C0C;
    int_valid = 1'b1; int_rd = 5'd1; int_data = 32'h1;
    tick();
    issue_rd = 5'd13;
    fpu_rd = 5'd13; fpu_data = 32'h0000_0D0D;
    int_rd = 5'd2; int_data = 32'h2;
    tick();
    q_rs1 = 5'd12; q_rs2 = 5'd13;
    #1;
    n_checks++;
    if (hazard !== 1'b1 || fpu_ready !== 1'b0) begin
      $display("FAIL pre_reset_state: got hazard=%b ready=%b want 1 0", hazard, fpu_ready); n_fail++;
    end
    rst = 1'b1;
    issue_rd = 5'd14; int_rd = 5'd3; int_data = 32'h3; fpu_rd = 5'd15;
    tick();
    rst = 1'b0;
    idle_inputs();
    q_rs1 = 5'd12; q_rs2 = 5'd14;
    #1;
    n_checks++;
    if ({rf_we, rf_a3, rf_wd3} !== wr(1'b0, 5'd0, 32'd0)) begin
      $display("FAIL reset_mid_outputs: got %h want %h", {rf_we, rf_a3, rf_wd3}, wr(1'b0, 5'd0, 32'd0)); n_fail++;
    end
    n_checks++;
    if (hazard !== 1'b0 || fpu_ready !== 1'b1) begin
      $display("FAIL reset_mid_state: got hazard=%b ready=%b want 0 1", hazard, fpu_ready); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rf_we !== 1'b0) begin
        $display("FAIL reset_mid_discard[%0d]: got we=%b a3=%0d want we=0", i, rf_we, rf_a3); n_fail++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_int_write();
    test_int_rd0();
    test_fpu_hazard();
    test_back_to_back();
    test_fpu_rd0();
    test_set_clear_same();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
